// File: rtl/outfifo_pkg.sv
// Shared definitions for the output-FIFO write arbiter: default widths,
// starvation limit and the arbiter state encoding.
package outfifo_pkg;

  localparam int OUTFIFO_DW         = 50;
  localparam int OUTFIFO_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    DAQ  = 2'd2
  } state_t;

endpackage

// File: rtl/outfifo_arb_wdog.sv
// DAQ idle-gap watchdog: counts enabled cycles and flags the CYCLES-th one.
// Only built when OUTFIFO_ARB_WDOG_EN is defined; otherwise no timer exists.
`ifdef OUTFIFO_ARB_WDOG_EN
module outfifo_arb_wdog #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_o = en_i && (cnt_q == CW'(CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || timeout_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/outfifo_wr_arb.sv
// Arbitrates trigger-info and DAQ frame words into one output FIFO with a
// registered write port. Optional DAQ idle watchdog: OUTFIFO_ARB_WDOG_EN.
module outfifo_wr_arb
  import outfifo_pkg::*;
#(
  parameter int DW          = OUTFIFO_DW,
  parameter int STARVE_MAX  = OUTFIFO_STARVE_MAX,
  parameter int WDOG_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig_req,
  input  logic [DW-1:0] trig_data,
  output logic          trig_ack,
  input  logic          daq_req,
  input  logic [DW-1:0] daq_data,
  input  logic          daq_last,
  output logic          daq_ack,
  input  logic          no_space,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_wren,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          wdog_err
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] din_q, din_d;
  logic          wren_q, wren_d;
  logic [15:0]   frame_q, frame_d;
  logic          daq_ok, daq_wins;
  logic          trig_ack_c, daq_ack_c;
  logic          wdog_to;

  // A frame may only start with FIFO headroom; once started it runs to daq_last.
  assign daq_ok   = daq_req && !no_space;
  assign daq_wins = daq_ok && (starve_q == SW'(STARVE_MAX));

  always_comb begin
    trig_ack_c = 1'b0;
    daq_ack_c  = 1'b0;
    state_d    = state_q;
    starve_d   = starve_q;
    unique case (state_q)
      IDLE: begin
        if (trig_req && !daq_wins) begin
          trig_ack_c = 1'b1;
          state_d    = TRIG;
          if (daq_ok) starve_d = starve_q + SW'(1);
        end else if (daq_ok) begin
          daq_ack_c = 1'b1;
          starve_d  = '0;
          if (!daq_last) state_d = DAQ;
        end
      end
      TRIG: state_d = IDLE;
      DAQ: begin
        if (daq_req) begin
          daq_ack_c = 1'b1;
          if (daq_last) state_d = IDLE;
        end else if (wdog_to) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wren_d  = trig_ack_c || daq_ack_c;
    din_d   = trig_ack_c ? trig_data : (daq_ack_c ? daq_data : din_q);
    frame_d = frame_q + ((daq_ack_c && daq_last) ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      din_q    <= '0;
      wren_q   <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      din_q    <= din_d;
      wren_q   <= wren_d;
      frame_q  <= frame_d;
    end
  end

  assign trig_ack  = trig_ack_c;
  assign daq_ack   = daq_ack_c;
  assign fifo_din  = din_q;
  assign fifo_wren = wren_q;
  assign frame_cnt = frame_q;
  assign busy      = (state_q != IDLE);

`ifdef OUTFIFO_ARB_WDOG_EN
  logic wdog_err_q;

  outfifo_arb_wdog #(
    .CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    ((state_q != DAQ) || daq_req),
    .en_i     ((state_q == DAQ) && !daq_req),
    .timeout_o(wdog_to)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_err_q <= 1'b0;
    end else begin
      wdog_err_q <= wdog_to;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog;
  assign unused_wdog = |WDOG_CYCLES;
  assign wdog_to     = 1'b0;
  assign wdog_err    = 1'b0;
`endif

endmodule

// File: tb/tb_outfifo_wr_arb.sv
// Directed bench for outfifo_wr_arb: arbitration, starvation, back-pressure,
// watchdog (either build) and mid-frame reset.
module tb_outfifo_wr_arb;

  localparam int DW = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trig_req;
  logic [DW-1:0] trig_data;
  logic          trig_ack;
  logic          daq_req;
  logic [DW-1:0] daq_data;
  logic          daq_last;
  logic          daq_ack;
  logic          no_space;
  logic [DW-1:0] fifo_din;
  logic          fifo_wren;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          wdog_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  outfifo_wr_arb #(
    .DW(DW),
    .STARVE_MAX(4),
    .WDOG_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .trig_req(trig_req), .trig_data(trig_data), .trig_ack(trig_ack),
    .daq_req(daq_req), .daq_data(daq_data), .daq_last(daq_last), .daq_ack(daq_ack),
    .no_space(no_space),
    .fifo_din(fifo_din), .fifo_wren(fifo_wren),
    .busy(busy), .frame_cnt(frame_cnt), .wdog_err(wdog_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] t0, t1, w0, w1, w2, w3;
    t0 = 50'h2_0000_0000_0001;
    t1 = 50'h1_2345_6789_ABCD;
    w0 = 50'h0_0000_0000_00A0;
    w1 = 50'h3_FFFF_0000_00A1;
    w2 = 50'h0_5555_AAAA_00A2;
    w3 = 50'h2_AAAA_5555_00A3;

    rst_n = 1'b0; trig_req = 1'b0; trig_data = '0; daq_req = 1'b0;
    daq_data = '0; daq_last = 1'b0; no_space = 1'b0;
    tick(); tick();
    chk("rst_wren", 64'(fifo_wren), 64'd0);
    chk("rst_din", 64'(fifo_din), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frames", 64'(frame_cnt), 64'd0);
    chk("rst_wdog", 64'(wdog_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single trigger word
    trig_req = 1'b1; trig_data = t0;
    settle();
    chk("t0_trig_ack", 64'(trig_ack), 64'd1);
    chk("t0_daq_ack", 64'(daq_ack), 64'd0);
    tick();
    trig_req = 1'b0;
    settle();
    chk("t0_wren", 64'(fifo_wren), 64'd1);
    chk("t0_din", 64'(fifo_din), 64'h2_0000_0000_0001);
    chk("t0_busy", 64'(busy), 64'd1);
    chk("t0_no_ack_in_trig", 64'(trig_ack), 64'd0);
    tick();
    chk("t0_wren_off", 64'(fifo_wren), 64'd0);
    chk("t0_busy_off", 64'(busy), 64'd0);

    // 4-word frame while trig_req held
    daq_req = 1'b1; daq_data = w0; daq_last = 1'b0;
    settle();
    chk("f_w0_ack", 64'(daq_ack), 64'd1);
    tick();
    trig_req = 1'b1; trig_data = t1; daq_data = w1;
    settle();
    chk("f_w1_ack", 64'(daq_ack), 64'd1);
    chk("f_w1_trig", 64'(trig_ack), 64'd0);
    chk("f_w0_din", 64'(fifo_din), 64'(w0));
    chk("f_busy", 64'(busy), 64'd1);
    tick();
    daq_data = w2;
    settle();
    chk("f_w2_ack", 64'(daq_ack), 64'd1);
    chk("f_w2_trig", 64'(trig_ack), 64'd0);
    chk("f_w1_din", 64'(fifo_din), 64'(w1));
    tick();
    daq_data = w3; daq_last = 1'b1;
    settle();
    chk("f_w3_ack", 64'(daq_ack), 64'd1);
    chk("f_w3_trig", 64'(trig_ack), 64'd0);
    chk("f_w2_din", 64'(fifo_din), 64'(w2));
    tick();
    daq_req = 1'b0; daq_last = 1'b0;
    settle();
    chk("f_after_trig", 64'(trig_ack), 64'd1);
    chk("f_after_daq", 64'(daq_ack), 64'd0);
    chk("f_w3_din", 64'(fifo_din), 64'(w3));
    chk("f_w3_wren", 64'(fifo_wren), 64'd1);
    chk("f_frames", 64'(frame_cnt), 64'd1);
    tick();
    trig_req = 1'b0;
    settle();
    chk("f_t1_din", 64'(fifo_din), 64'(t1));
    tick();
    chk("f_idle_wren", 64'(fifo_wren), 64'd0);

    // Starvation: both held, 4 trigger grants then a DAQ frame
    trig_req = 1'b1; daq_req = 1'b1; daq_last = 1'b0;
    for (int g = 0; g < 4; g++) begin
      settle();
      chk("st_trig_grant", 64'(trig_ack), 64'd1);
      chk("st_daq_held", 64'(daq_ack), 64'd0);
      tick();
      settle();
      chk("st_trig_gap", 64'(trig_ack | daq_ack), 64'd0);
      tick();
    end
    settle();
    chk("st_daq_wins", 64'(daq_ack), 64'd1);
    chk("st_trig_lose", 64'(trig_ack), 64'd0);
    tick();
    daq_last = 1'b1;
    settle();
    chk("st_daq_last", 64'(daq_ack), 64'd1);
    chk("st_trig_blocked", 64'(trig_ack), 64'd0);
    tick();
    daq_last = 1'b0;
    settle();
    chk("st_repeat_trig", 64'(trig_ack), 64'd1);
    chk("st_frames", 64'(frame_cnt), 64'd2);
    trig_req = 1'b0; daq_req = 1'b0;
    tick();

    // Back-pressure
    daq_req = 1'b1; no_space = 1'b1;
    settle();
    chk("ns_no_start", 64'(daq_ack), 64'd0);
    tick();
    chk("ns_idle", 64'(busy), 64'd0);
    trig_req = 1'b1;
    settle();
    chk("ns_trig_wins", 64'(trig_ack), 64'd1);
    chk("ns_trig_daq0", 64'(daq_ack), 64'd0);
    trig_req = 1'b0;
    settle();
    chk("ns_still_blocked", 64'(daq_ack), 64'd0);
    no_space = 1'b0;
    settle();
    chk("ns_release_start", 64'(daq_ack), 64'd1);
    tick();
    no_space = 1'b1;
    settle();
    chk("ns_midframe_ack", 64'(daq_ack), 64'd1);
    tick();
    daq_last = 1'b1;
    settle();
    chk("ns_last_ack", 64'(daq_ack), 64'd1);
    tick();
    daq_req = 1'b0; daq_last = 1'b0; no_space = 1'b0;
    chk("ns_frames", 64'(frame_cnt), 64'd3);
    chk("ns_busy_off", 64'(busy), 64'd0);

    // Idle gap inside a frame
    daq_req = 1'b1;
    tick();
    daq_req = 1'b0;
`ifdef OUTFIFO_ARB_WDOG_EN
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("wd_waiting_busy", 64'(busy), 64'd1);
      chk("wd_waiting_err", 64'(wdog_err), 64'd0);
    end
    tick();
    chk("wd_err_pulse", 64'(wdog_err), 64'd1);
    chk("wd_idle", 64'(busy), 64'd0);
    chk("wd_frames", 64'(frame_cnt), 64'd3);
    tick();
    chk("wd_err_drop", 64'(wdog_err), 64'd0);
`else
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("nowd_busy", 64'(busy), 64'd1);
      chk("nowd_err", 64'(wdog_err), 64'd0);
    end
`endif
    daq_req = 1'b1; daq_last = 1'b1;
    settle();
    chk("gap_end_ack", 64'(daq_ack), 64'd1);
    tick();
    daq_req = 1'b0; daq_last = 1'b0;
    chk("gap_end_frames", 64'(frame_cnt), 64'd4);
    chk("gap_end_idle", 64'(busy), 64'd0);

    // Reset mid-frame
    daq_req = 1'b1; daq_data = w0;
    tick();
    chk("rf_busy", 64'(busy), 64'd1);
    daq_data = w1; rst_n = 1'b0;
    tick();
    chk("rf_wren", 64'(fifo_wren), 64'd0);
    chk("rf_busy0", 64'(busy), 64'd0);
    chk("rf_frames0", 64'(frame_cnt), 64'd0);
    chk("rf_din0", 64'(fifo_din), 64'd0);
    rst_n = 1'b1; daq_req = 1'b0;
    tick();
    chk("rf_after_wren", 64'(fifo_wren), 64'd0);
    chk("rf_after_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
